// File: rtl/instr_prefetch_pkg.sv
// instr_prefetch_pkg: fetch FSM state type and default prefetch configuration
package instr_prefetch_pkg;
  typedef enum logic [1:0] {REQ, WAIT, DROP} pf_state_e;
  localparam int PF_DEPTH = 4;
  localparam logic [15:0] PF_RESET_VEC = 16'h0000;
  localparam int PF_W = 24;
endpackage

// File: rtl/pf_fifo.sv
// pf_fifo: small FIFO of {addr, byte} entries with flush and occupancy level
module pf_fifo import instr_prefetch_pkg::*; #(
  parameter int DEPTH = PF_DEPTH,
  parameter int W = PF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [3:0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [3:0] cnt_q;
  logic do_pop, do_push;
  assign do_pop = pop_i && cnt_q != 4'd0;
  assign do_push = push_i && (cnt_q != 4'(DEPTH) || do_pop);
  assign dout_o = mem_q[rd_q];
  assign level_o = cnt_q;
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + 4'(do_push) - 4'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push && !rst && !flush_i) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: CODE byte prefetch queue with jump flush; PF_BYPASS_EN forwards acked data into an empty queue
module instr_prefetch import instr_prefetch_pkg::*; #(
  parameter int DEPTH = PF_DEPTH,
  parameter logic [15:0] RESET_VEC = PF_RESET_VEC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        fetch_req,
  output logic [15:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [7:0]  fetch_data,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  output logic [15:0] out_addr,
  input  logic        pop,
  input  logic        jump,
  input  logic [15:0] jump_addr,
  output logic [3:0]  level
);
  pf_state_e state_q, state_d;
  logic [15:0] pc_q, pc_d, hold_q, hold_d;
  logic [23:0] head;
  logic [3:0] fifo_lvl;
  logic fifo_empty, pop_fifo, room, accept, byp, push;
  pf_fifo #(.DEPTH(DEPTH), .W(PF_W)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push_i(push),
    .pop_i(pop_fifo),
    .flush_i(jump),
    .din_i({fetch_addr, fetch_data}),
    .dout_o(head),
    .level_o(fifo_lvl)
  );
  always_comb begin
    fifo_empty = fifo_lvl == 4'd0;
    pop_fifo = pop && !fifo_empty && !jump;
    // a head byte leaving this cycle frees a slot for a new request
    room = (fifo_lvl - 4'(pop_fifo)) < 4'(DEPTH);
    fetch_req = !reset && (state_q != REQ || room);
    fetch_addr = state_q == DROP ? hold_q : pc_q;
    accept = fetch_req && fetch_ack && state_q != DROP && !jump;
`ifdef PF_BYPASS_EN
    byp = fifo_empty && accept;
`else
    byp = 1'b0;
`endif
    out_valid = !fifo_empty || byp;
    out_byte = byp ? fetch_data : fifo_empty ? 8'h00 : head[7:0];
    out_addr = byp ? fetch_addr : fifo_empty ? 16'h0000 : head[23:8];
    push = accept && !(byp && pop);
    level = fifo_lvl;
    pc_d = jump ? jump_addr : accept ? pc_q + 16'd1 : pc_q;
    hold_d = fetch_addr;
    state_d = (fetch_ack || !fetch_req) ? REQ : (jump || state_q == DROP) ? DROP : WAIT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= REQ;
      pc_q <= RESET_VEC;
      hold_q <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      hold_q <= hold_d;
    end
  end
endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: table-driven and scoreboard checks of instr_prefetch against a latency-configurable CODE memory
module tb_instr_prefetch;
  logic clk = 1'b0;
  logic reset, fetch_req, fetch_ack, out_valid, pop, jump;
  logic [15:0] fetch_addr, out_addr, jump_addr;
  logic [7:0] fetch_data, out_byte;
  logic [3:0] level;
  int lat = 0, cnt = 0, errs = 0, nchk = 0, n;
  logic [15:0] sbq[$];
`ifdef PF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic        pop, jump;
    logic [15:0] ja;
    logic [3:0]  lvl;
    logic        vld, req;
    logic [15:0] fa;
  } vec_t;
  vec_t tv [19];

  always #5 clk = ~clk;

  instr_prefetch dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .out_valid(out_valid), .out_byte(out_byte), .out_addr(out_addr),
    .pop(pop), .jump(jump), .jump_addr(jump_addr), .level(level)
  );

  // CODE memory: acks after lat wait cycles, returns addr[7:0]
  always_comb begin
    fetch_ack = fetch_req && cnt >= lat;
    fetch_data = fetch_addr[7:0];
  end
  always @(posedge clk) cnt <= (fetch_req && !fetch_ack) ? cnt + 1 : 0;

  function automatic vec_t v(logic p, logic j, logic [15:0] ja, logic [3:0] l,
                             logic vd, logic r, logic [15:0] fa);
    return '{p, j, ja, l, vd, r, fa};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic refill(input logic [15:0] a);
    sbq.delete();
    for (int i = 0; i < 40; i++) sbq.push_back(a + 16'(i));
  endtask

  task automatic sb();
    if (pop && out_valid && !jump) begin
      if (sbq.size() == 0) begin
        nchk++;
        errs++;
        $display("FAIL sb_underflow: got pop at %0h expected no output", out_addr);
      end else begin
        chk("sb_addr", out_addr, sbq[0]);
        chk("sb_byte", out_byte, sbq[0][7:0]);
        void'(sbq.pop_front());
      end
    end
    if (jump) refill(jump_addr);
  endtask

  task automatic adv();
    sb();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; pop = 1'b0; jump = 1'b0; jump_addr = 16'h0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req", fetch_req, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_lvl", level, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    refill(16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = v(0, 0, 16'h0,    4'd0, BYP, 1, 16'h0000);
    tv[1]  = v(0, 0, 16'h0,    4'd1, 1,   1, 16'h0001);
    tv[2]  = v(0, 0, 16'h0,    4'd2, 1,   1, 16'h0002);
    tv[3]  = v(0, 0, 16'h0,    4'd3, 1,   1, 16'h0003);
    tv[4]  = v(0, 0, 16'h0,    4'd4, 1,   0, 16'h0004);
    tv[5]  = v(1, 0, 16'h0,    4'd4, 1,   1, 16'h0004);
    tv[6]  = v(1, 0, 16'h0,    4'd4, 1,   1, 16'h0005);
    tv[7]  = v(1, 0, 16'h0,    4'd4, 1,   1, 16'h0006);
    tv[8]  = v(0, 1, 16'hFFFE, 4'd4, 1,   0, 16'h0007);
    tv[9]  = v(0, 0, 16'h0,    4'd0, BYP, 1, 16'hFFFE);
    tv[10] = v(0, 0, 16'h0,    4'd1, 1,   1, 16'hFFFF);
    tv[11] = v(0, 0, 16'h0,    4'd2, 1,   1, 16'h0000);
    tv[12] = v(0, 0, 16'h0,    4'd3, 1,   1, 16'h0001);
    tv[13] = v(0, 0, 16'h0,    4'd4, 1,   0, 16'h0002);
    tv[14] = v(1, 0, 16'h0,    4'd4, 1,   1, 16'h0002);
    tv[15] = v(1, 0, 16'h0,    4'd4, 1,   1, 16'h0003);
    tv[16] = v(1, 0, 16'h0,    4'd4, 1,   1, 16'h0004);
    tv[17] = v(1, 0, 16'h0,    4'd4, 1,   1, 16'h0005);
    tv[18] = v(0, 0, 16'h0,    4'd4, 1,   0, 16'h0006);

    lat = 0;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      pop = tv[i].pop; jump = tv[i].jump; jump_addr = tv[i].ja;
      @(negedge clk);
      chk($sformatf("v%0d_lvl", i), level, tv[i].lvl);
      chk($sformatf("v%0d_valid", i), out_valid, tv[i].vld);
      chk($sformatf("v%0d_req", i), fetch_req, tv[i].req);
      chk($sformatf("v%0d_faddr", i), fetch_addr, tv[i].fa);
      adv();
    end
    pop = 0; jump = 0;

    // jump while a slow request is outstanding
    lat = 3;
    do_reset();
    @(negedge clk); chk("w_req", fetch_req, 1); adv();
    jump = 1; jump_addr = 16'h1234;
    @(negedge clk); chk("w_addr", fetch_addr, 16'h0000); adv();
    jump = 0;
    @(negedge clk); chk("drop_req", fetch_req, 1); chk("drop_addr", fetch_addr, 16'h0000); adv();
    @(negedge clk); chk("drop_ack", fetch_ack, 1); chk("drop_addr2", fetch_addr, 16'h0000); adv();
    @(negedge clk); chk("redir_addr", fetch_addr, 16'h1234); chk("redir_lvl", level, 0); adv();
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin adv(); @(negedge clk); n++; end
    if (!out_valid) begin
      nchk++; errs++;
      $display("FAIL redir_timeout: got out_valid=0 expected 1 within 20 cycles");
    end else begin
      chk("redir_oaddr", out_addr, 16'h1234);
      chk("redir_obyte", out_byte, 8'h34);
      chk("redir_lvl1", level, BYP ? 0 : 1);
    end
    adv();

    // jump coincident with ack and pop
    lat = 0;
    do_reset();
    adv(); adv();
    pop = 1; jump = 1; jump_addr = 16'h0ABC;
    @(negedge clk); chk("jc_ack", fetch_ack, 1); adv();
    pop = 0; jump = 0;
    @(negedge clk); chk("jc_lvl", level, 0); chk("jc_faddr", fetch_addr, 16'h0ABC); adv();
    @(negedge clk); chk("jc_lvl1", level, 1); chk("jc_valid", out_valid, 1); chk("jc_oaddr", out_addr, 16'h0ABC); adv();

    // empty queue, ack and pop in the same cycle
    jump = 1; jump_addr = 16'h5500;
    @(negedge clk); adv();
    jump = 0; pop = 1;
    @(negedge clk); chk("bp_valid", out_valid, BYP); adv();
    pop = 0;
    @(negedge clk); chk("bp_lvl", level, BYP ? 0 : 1); chk("bp_oaddr", out_addr, BYP ? 16'h5501 : 16'h5500); adv();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
